// File: rtl/rr_pkg.sv
// Shared record/replay definitions.
// Unit length encoding lives here so the packer and unpacker agree on it.
package rr_pkg;

    localparam int RR_CHANNEL_WIDTH_BITS = 16;
    localparam int RR_MAX_CHANNELS = 8;

    typedef logic [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_widths_t;

    typedef enum logic [1:0] {
        RR_UNPACK_IDLE,
        RR_UNPACK_RUN,
        RR_UNPACK_DRAIN,
        RR_UNPACK_FINISH
    } rr_unpack_state_e;

    // Header bits plus the payload of every channel flagged in the bitmap.
    function automatic int unsigned rr_unit_len(
        input logic [RR_MAX_CHANNELS-1:0] bitmap,
        input rr_widths_t widths,
        input int unsigned hdr_bits
    );
        int unsigned len;
        len = hdr_bits;
        for (int i = 0; i < RR_MAX_CHANNELS; i++) begin
            if (bitmap[i]) len += 32'(widths[i]);
        end
        return len;
    endfunction

endpackage

// File: rtl/rr_bit_shifter.sv
// Barrel shift with merge for the unpacker's double-width bit buffer.
// Kept separate so a pipeline register can be slotted in for timing.
module rr_bit_shifter #(
    parameter int IN_WIDTH = 512,
    parameter int LEN_W = 7,
    parameter int FILL_W = 11
) (
    input  logic [2*IN_WIDTH-1:0] sbuf,
    input  logic [FILL_W-1:0]     fill,
    input  logic [IN_WIDTH-1:0]   din,
    input  logic [LEN_W-1:0]      len,
    input  logic                  push,
    input  logic                  pop,
    output logic [2*IN_WIDTH-1:0] sbuf_nxt,
    output logic [FILL_W-1:0]     fill_nxt
);

    logic [2*IN_WIDTH-1:0] kept;
    logic [FILL_W-1:0] base;

    always_comb begin
        kept = pop ? (sbuf >> len) : sbuf;
        base = pop ? (fill - FILL_W'(len)) : fill;
        sbuf_nxt = kept;
        fill_nxt = base;
        if (push) begin
            sbuf_nxt = kept | ({{IN_WIDTH{1'b0}}, din} << base);
            fill_nxt = base + FILL_W'(IN_WIDTH);
        end
    end

endmodule

// File: rtl/rr_replay_unpacker.sv
// Splits the dense replay bitstream back into variable-length logging units.
// Units are LSB-first and back-to-back; length comes from the logb bitmap.
module rr_replay_unpacker
    import rr_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = 2,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0]
        CHANNEL_WIDTHS = {16'd64, 16'd32},
    parameter int LOGE_CHANNEL_CNT = 2,
    parameter int IN_WIDTH = 512,
    localparam int HDR_BITS = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
    localparam rr_widths_t WIDTHS_EXT = rr_widths_t'(CHANNEL_WIDTHS),
    localparam int FULL_WIDTH = int'(rr_unit_len('1, WIDTHS_EXT, HDR_BITS)),
    localparam int LEN_W = $clog2(FULL_WIDTH + 1),
    localparam int FILL_W = $clog2(2 * IN_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   din,
    input  logic                  din_valid,
    input  logic                  din_last,
    output logic                  din_ready,
    output logic [FULL_WIDTH-1:0] dout,
    output logic [LEN_W-1:0]      dout_len,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  done,
    output logic [63:0]           unit_cnt,
    output logic [FILL_W-1:0]     residual_bits
);

    generate
        if (IN_WIDTH < FULL_WIDTH) begin : g_width_chk
            $error("rr_replay_unpacker: IN_WIDTH smaller than a full unit");
        end
    endgenerate

    logic [2*IN_WIDTH-1:0] sbuf, sbuf_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic last_seen;
    logic [LEN_W-1:0] len;
    logic [FULL_WIDTH-1:0] unit_mask;
    logic pad, avail, push, pop, drain;
    rr_unpack_state_e state, state_nxt;

    assign len = LEN_W'(rr_unit_len(
        RR_MAX_CHANNELS'(sbuf[LOGB_CHANNEL_CNT-1:0]), WIDTHS_EXT, HDR_BITS));

    // An all-zero header after the final beat is tail padding, not a unit.
    assign pad = last_seen && (sbuf[HDR_BITS-1:0] == '0);
    assign avail = (fill >= FILL_W'(LOGB_CHANNEL_CNT))
                && (fill >= FILL_W'(len)) && !pad;
    assign pop = avail && (!dout_valid || dout_ready);
    assign din_ready = (fill <= FILL_W'(IN_WIDTH)) && !last_seen;
    assign push = din_valid && din_ready;
    assign drain = (state == RR_UNPACK_DRAIN) && last_seen
                && !avail && !dout_valid;
    assign unit_mask = ~({FULL_WIDTH{1'b1}} << len);

    rr_bit_shifter #(
        .IN_WIDTH(IN_WIDTH),
        .LEN_W(LEN_W),
        .FILL_W(FILL_W)
    ) u_shift (
        .sbuf(sbuf),
        .fill(fill),
        .din(din),
        .len(len),
        .push(push),
        .pop(pop),
        .sbuf_nxt(sbuf_nxt),
        .fill_nxt(fill_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RR_UNPACK_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RR_UNPACK_IDLE, RR_UNPACK_FINISH: begin
                if (push) state_nxt = din_last ? RR_UNPACK_DRAIN : RR_UNPACK_RUN;
                else state_nxt = RR_UNPACK_IDLE;
            end
            RR_UNPACK_RUN: begin
                if (push && din_last) state_nxt = RR_UNPACK_DRAIN;
            end
            RR_UNPACK_DRAIN: begin
                if (drain) state_nxt = RR_UNPACK_FINISH;
            end
            default: state_nxt = RR_UNPACK_IDLE;
        endcase
    end

    always_comb begin
        done = (state == RR_UNPACK_FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbuf <= '0;
            fill <= '0;
            last_seen <= 1'b0;
            residual_bits <= '0;
        end else if (drain) begin
            sbuf <= '0;
            fill <= '0;
            last_seen <= 1'b0;
            residual_bits <= fill;
        end else begin
            sbuf <= sbuf_nxt;
            fill <= fill_nxt;
            if (push && din_last) last_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            dout_len <= '0;
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout <= sbuf[FULL_WIDTH-1:0] & unit_mask;
            dout_len <= len;
            dout_valid <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) unit_cnt <= '0;
        else if (dout_valid && dout_ready && (unit_cnt != '1))
            unit_cnt <= unit_cnt + 64'd1;
    end

endmodule

// File: tb/tb_rr_replay_unpacker.sv
// Self-checking bench for rr_replay_unpacker: a bit-queue packer model
// feeds the DUT and a unit queue scores every emitted unit.
module tb_rr_replay_unpacker;

    localparam int IW = 512;
    localparam int FW = 100;
    localparam int LW = 7;
    localparam int FLW = 11;

    logic clk = 1'b0;
    logic rst;
    logic [IW-1:0] din;
    logic din_valid, din_last, din_ready;
    logic [FW-1:0] dout;
    logic [LW-1:0] dout_len;
    logic dout_valid, dout_ready, done;
    logic [63:0] unit_cnt;
    logic [FLW-1:0] residual_bits;

    rr_replay_unpacker dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .din_last(din_last),
        .din_ready(din_ready),
        .dout(dout),
        .dout_len(dout_len),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .done(done),
        .unit_cnt(unit_cnt),
        .residual_bits(residual_bits)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        logic [FW-1:0] data;
    } unit_t;

    typedef struct {
        logic [1:0] bm;
        logic [1:0] loge;
        int len;
        int res;
    } vec_t;

    unit_t exp_q[$];
    unit_t head;
    bit stream[$];
    logic [IW-1:0] beats[$];
    int hs_cyc[$];
    int tests = 0, fails = 0;
    int units_total = 0, done_cnt = 0, dc_base = 0;
    int hs_cnt = 0, cyc = 0, pad_bits = 0, last_len = 0;
    logic prev_stall = 1'b0;
    bit stop_rand;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] rnd_pay();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[FW-1:0];
    endfunction

    // Reference packer: unit length straight from the channel widths.
    function automatic void add_unit(input logic [1:0] bm,
                                     input logic [1:0] loge,
                                     input logic [FW-1:0] pay);
        unit_t u;
        u.len = 4 + (bm[0] ? 32 : 0) + (bm[1] ? 64 : 0);
        u.data = '0;
        for (int i = 0; i < u.len; i++)
            u.data[i] = (i < 2) ? bm[i] : (i < 4) ? loge[i-2] : pay[i-4];
        exp_q.push_back(u);
        for (int i = 0; i < u.len; i++) stream.push_back(u.data[i]);
        units_total++;
    endfunction

    function automatic void build_beats();
        int nb;
        logic [IW-1:0] d;
        nb = (stream.size() + IW - 1) / IW;
        beats.delete();
        for (int b = 0; b < nb; b++) begin
            d = '0;
            for (int i = 0; i < IW; i++)
                if (b * IW + i < stream.size()) d[i] = stream[b * IW + i];
            beats.push_back(d);
        end
        pad_bits = nb * IW - stream.size();
        stream.delete();
    endfunction

    task automatic put_beat(input logic [IW-1:0] d, input logic last);
        int n;
        n = 0;
        din = d;
        din_last = last;
        din_valid = 1'b1;
        while (!din_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!din_ready) begin
            tests++;
            fails++;
            $display("FAIL beat_accept: din_ready 0 want 1");
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_last = 1'b0;
    endtask

    task automatic send_all();
        for (int b = 0; b < beats.size(); b++)
            put_beat(beats[b], b == beats.size() - 1);
    endtask

    task automatic expect_done(input string name, input int res);
        int n;
        n = 0;
        while (done_cnt == dc_base && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == dc_base) begin
            tests++;
            fails++;
            $display("FAIL %s_done: no done pulse, want 1", name);
        end
        repeat (4) @(negedge clk);
        check({name, "_done_pulses"}, done_cnt - dc_base, 1);
        check({name, "_residual"}, residual_bits, res);
        check({name, "_unit_cnt"}, unit_cnt, units_total);
        check({name, "_units_left"}, exp_q.size(), 0);
        dc_base = done_cnt;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid cycle must present the oldest pending unit.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_valid", dout_valid, 1'b1);
            if (done) done_cnt++;
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_unit: got len %0d want none", dout_len);
                end else begin
                    head = exp_q[0];
                    check("unit_len", dout_len, head.len);
                    check("unit_data", dout, head.data);
                    if (dout_ready) void'(exp_q.pop_front());
                end
                if (dout_ready) begin
                    hs_cyc.push_back(cyc);
                    hs_cnt++;
                    last_len = int'(dout_len);
                end
            end
            prev_stall = dout_valid && !dout_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        int h0, run;
        tbl[0] = '{2'b00, 2'b11, 4, 508};
        tbl[1] = '{2'b01, 2'b01, 36, 476};
        tbl[2] = '{2'b10, 2'b10, 68, 444};
        tbl[3] = '{2'b11, 2'b11, 100, 412};

        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        din_last = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_din_ready", din_ready, 1'b1);
        check("reset_dout_valid", dout_valid, 1'b0);
        check("reset_unit_cnt", unit_cnt, 0);
        check("reset_residual", residual_bits, 0);
        check("reset_done", done, 1'b0);
        @(posedge clk);
        #1;

        // Single beat: 4-bit then 36-bit unit, zero padded.
        add_unit(2'b00, 2'b11, '0);
        add_unit(2'b01, 2'b10, rnd_pay());
        build_beats();
        send_all();
        expect_done("single", 472);
        check("single_last_len", last_len, 36);

        for (int i = 0; i < 4; i++) begin
            add_unit(tbl[i].bm, tbl[i].loge, rnd_pay());
            build_beats();
            send_all();
            expect_done("tbl", tbl[i].res);
            check("tbl_len", last_len, tbl[i].len);
        end

        // Straddle: 100-bit unit at bit 480 spans both beats.
        for (int i = 0; i < 4; i++) add_unit(2'b11, 2'b01, rnd_pay());
        add_unit(2'b10, 2'b10, rnd_pay());
        for (int i = 0; i < 3; i++) add_unit(2'b00, 2'b11, '0);
        add_unit(2'b11, 2'b11, rnd_pay());
        build_beats();
        h0 = hs_cnt;
        put_beat(beats[0], 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("straddle_units_before", hs_cnt - h0, 8);
        check("straddle_no_dout", dout_valid, 1'b0);
        put_beat(beats[1], 1'b1);
        check("straddle_lat0", dout_valid, 1'b0);
        @(posedge clk);
        #1;
        check("straddle_lat1", dout_valid, 1'b1);
        check("straddle_len", dout_len, 100);
        expect_done("straddle", 444);

        // Throughput: 15 full units over 3 beats.
        for (int i = 0; i < 15; i++) add_unit(2'b11, 2'b01, rnd_pay());
        build_beats();
        h0 = hs_cyc.size();
        put_beat(beats[0], 1'b0);
        put_beat(beats[1], 1'b0);
        check("tput_full_blocks", din_ready, 1'b0);
        put_beat(beats[2], 1'b1);
        expect_done("tput", 36);
        run = 0;
        for (int i = h0 + 1; i < hs_cyc.size(); i++)
            if (hs_cyc[i] - hs_cyc[i-1] == 1) run++;
        check("tput_b2b", run, 14);

        // Backpressure: consumer stalls 10 cycles mid-stream.
        for (int i = 0; i < 5; i++) add_unit(2'b11, 2'b10, rnd_pay());
        for (int i = 0; i < 3; i++) add_unit(2'b00, 2'b01, '0);
        for (int i = 0; i < 10; i++) add_unit(2'b11, 2'b11, rnd_pay());
        build_beats();
        fork
            send_all();
            begin
                repeat (3) @(posedge clk);
                #1 dout_ready = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    check("bp_din_blocked", din_ready, 1'b0);
                end
                dout_ready = 1'b1;
            end
        join
        expect_done("bp", 24);

        // Reset mid-stream with fill=300 and a unit held in dout.
        add_unit(2'b11, 2'b01, rnd_pay());
        add_unit(2'b11, 2'b01, rnd_pay());
        for (int i = 0; i < 3; i++) add_unit(2'b00, 2'b10, '0);
        for (int i = 0; i < 3; i++) add_unit(2'b11, 2'b01, rnd_pay());
        build_beats();
        put_beat(beats[0], 1'b0);
        repeat (5) @(posedge clk);
        #1 dout_ready = 1'b0;
        check("rst_pre_valid", dout_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_dout", dout, 0);
        check("rst_dout_len", dout_len, 0);
        check("rst_unit_cnt", unit_cnt, 0);
        check("rst_residual", residual_bits, 0);
        check("rst_done", done, 1'b0);
        exp_q.delete();
        units_total = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        dout_ready = 1'b1;
        check("rst_din_ready", din_ready, 1'b1);
        add_unit(2'b01, 2'b11, rnd_pay());
        add_unit(2'b11, 2'b01, rnd_pay());
        build_beats();
        send_all();
        expect_done("post_rst", 376);

        // Random mixed units over 20 beats with random backpressure.
        while (stream.size() < 19 * IW + 200)
            add_unit(2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)),
                     rnd_pay());
        build_beats();
        check("rand_beats", beats.size(), 20);
        stop_rand = 1'b0;
        fork
            begin
                send_all();
                expect_done("rand", pad_bits);
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1 dout_ready = ($urandom_range(0, 3) != 0);
                end
                dout_ready = 1'b1;
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
